// File: rtl/quad_pixel_reader_if.sv
// quad_pixel_reader_if
//
// Bundles the tile-request controls, the dedicated data-memory read port and
// the outgoing pixel stream of quad_pixel_reader.
//
// Parameters:
//   ADDR_W - data-memory address width
//
// Signals:
//   start, cuadrante            - tile read request and tile select (row [3:2], col [1:0])
//   busy, done                  - frame in progress / one-cycle end-of-frame pulse
//   mem_rd_en, mem_addr         - read strobe and address toward data memory
//   mem_rdata                   - read data, valid one cycle after mem_rd_en
//   pixel, pixel_valid,
//   pixel_ready, pixel_last     - pixel stream
//
// Stream handshake: a pixel transfers on every rising edge where pixel_valid
// and pixel_ready are both 1. Once pixel_valid is raised it stays high, and
// pixel/pixel_last stay unchanged, until that transfer happens; pixel_ready
// may be driven freely and may depend on pixel_valid.
//
// Modports:
//   master - the reader itself
//   slave  - the memory / stream sink / requester environment
interface quad_pixel_reader_if #(
  parameter int ADDR_W = 18
);
  logic              start;
  logic [3:0]        cuadrante;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        pixel;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              pixel_last;

  modport master (
    input  start, cuadrante, mem_rdata, pixel_ready,
    output busy, done, mem_rd_en, mem_addr, pixel, pixel_valid, pixel_last
  );

  modport slave (
    output start, cuadrante, mem_rdata, pixel_ready,
    input  busy, done, mem_rd_en, mem_addr, pixel, pixel_valid, pixel_last
  );
endinterface

// File: rtl/quad_pixel_reader.sv
// quad_pixel_reader
//
// Reads one GRID x GRID tile of an 8-bit framebuffer back out of data memory
// and streams its pixels in raster order. Addresses are generated
// incrementally (a line-base register advances by IMG_W per tile row), and a
// two-entry credit scheme keeps reads-in-flight plus buffered pixels <= 2.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-high; flushes FIFO and drops any read in flight
//   bus      - quad_pixel_reader_if.master (request, memory port, pixel stream)
//   stateDbg - current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Optional feature macro: QUAD_READER_BORDER_EN -- when defined, pixels on the
// tile's outer ring are replaced by 8'hFF (memory reads are unchanged).
module quad_pixel_reader #(
  parameter int IMG_W     = 400,
  parameter int IMG_H     = 400,
  parameter int GRID      = 4,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  quad_pixel_reader_if.master  bus,
  output logic [1:0]           stateDbg
);

  localparam int TW = IMG_W / GRID;
  localparam int TH = IMG_H / GRID;

  localparam logic [15:0]       X_LAST     = 16'(TW - 1);
  localparam logic [15:0]       Y_LAST     = 16'(TH - 1);
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] TILE_ROW_A = ADDR_W'(TH * IMG_W);
  localparam logic [ADDR_W-1:0] TILE_COL_A = ADDR_W'(TW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, stateNext;
  logic [15:0]       xCnt, yCnt;
  logic [ADDR_W-1:0] addrReg, lineBase, tileOrigin;
  logic              inFlight, inFlightLast;
  logic [1:0]        fifoCount;
  logic [7:0]        headData, tailData;
  logic              headLast, tailLast;
  logic [1:0]        used;
  logic              pop, rdEn, atLastPos, pixelValid, doneReg;
  logic [7:0]        pushData;

  // Tile origin multiplies only 2-bit selects by constants; this is evaluated
  // once at start and never sits in the per-pixel address path.
  assign tileOrigin = BASE_A
                    + ADDR_W'(bus.cuadrante[3:2]) * TILE_ROW_A
                    + ADDR_W'(bus.cuadrante[1:0]) * TILE_COL_A;

  assign pixelValid = (fifoCount != 2'd0);
  assign pop        = pixelValid && bus.pixel_ready;
  assign used       = fifoCount + {1'b0, inFlight};
  // A handshake in this cycle frees a slot, so a read may reuse it at once.
  assign rdEn       = (state == RUN) && ((used < 2'd2) || pop);
  assign atLastPos  = (xCnt == X_LAST) && (yCnt == Y_LAST);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.start) stateNext = RUN;
      RUN:     if (rdEn && atLastPos) stateNext = DRAIN;
      DRAIN:   if (pop && bus.pixel_last) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

`ifdef QUAD_READER_BORDER_EN
  logic inFlightBorder;

  always_ff @(posedge clk) begin
    if (reset) inFlightBorder <= 1'b0;
    else       inFlightBorder <= rdEn && ((xCnt == 16'd0) || (xCnt == X_LAST) ||
                                          (yCnt == 16'd0) || (yCnt == Y_LAST));
  end

  assign pushData = inFlightBorder ? 8'hFF : bus.mem_rdata;
`else
  assign pushData = bus.mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      doneReg      <= 1'b0;
      xCnt         <= '0;
      yCnt         <= '0;
      addrReg      <= '0;
      lineBase     <= '0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
      fifoCount    <= '0;
      headData     <= '0;
      tailData     <= '0;
      headLast     <= 1'b0;
      tailLast     <= 1'b0;
    end else begin
      state   <= stateNext;
      doneReg <= (state == DRAIN) && pop && bus.pixel_last;

      if (state == IDLE && bus.start) begin
        xCnt     <= '0;
        yCnt     <= '0;
        addrReg  <= tileOrigin;
        lineBase <= tileOrigin;
      end else if (rdEn) begin
        if (xCnt == X_LAST) begin
          xCnt     <= '0;
          yCnt     <= yCnt + 16'd1;
          lineBase <= lineBase + STRIDE_A;
          addrReg  <= lineBase + STRIDE_A;
        end else begin
          xCnt    <= xCnt + 16'd1;
          addrReg <= addrReg + ADDR_W'(1);
        end
      end

      // One-cycle read latency: the flag marks which cycle's mem_rdata is ours.
      inFlight     <= rdEn;
      inFlightLast <= rdEn && atLastPos;

      // Two-entry FIFO; the credit rule guarantees no push into a full FIFO
      // without a simultaneous pop.
      unique case ({inFlight, pop})
        2'b10: begin
          if (fifoCount == 2'd0) begin
            headData <= pushData;
            headLast <= inFlightLast;
          end else begin
            tailData <= pushData;
            tailLast <= inFlightLast;
          end
          fifoCount <= fifoCount + 2'd1;
        end
        2'b01: begin
          headData  <= tailData;
          headLast  <= tailLast;
          fifoCount <= fifoCount - 2'd1;
        end
        2'b11: begin
          if (fifoCount == 2'd1) begin
            headData <= pushData;
            headLast <= inFlightLast;
          end else begin
            headData <= tailData;
            headLast <= tailLast;
            tailData <= pushData;
            tailLast <= inFlightLast;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = doneReg;
  assign bus.mem_rd_en   = rdEn;
  assign bus.mem_addr    = addrReg;
  assign bus.pixel       = headData;
  assign bus.pixel_valid = pixelValid;
  assign bus.pixel_last  = headLast && pixelValid;
  assign stateDbg        = state;

endmodule

// File: tb/tb_quad_pixel_reader.sv
module tb_quad_pixel_reader;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  quad_pixel_reader_if #(.ADDR_W(18)) bus ();

  quad_pixel_reader dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .stateDbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: mem[a] = a[7:0], one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[7:0];
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];       // {last, pixel}
  logic [17:0] exp_addr_q[$];
  bit          mon_en = 0;
  int          m_issued, m_acc;
  bit          prev_stall;
  logic [7:0]  prev_pix;
  logic        prev_last;

  task automatic push_frame(input logic [3:0] q);
    int a;
    logic [7:0] d;
    for (int y = 0; y < 100; y++) begin
      for (int x = 0; x < 100; x++) begin
        a = (int'(q[3:2]) * 100 + y) * 400 + int'(q[1:0]) * 100 + x;
        d = a[7:0];
`ifdef QUAD_READER_BORDER_EN
        if (x == 0 || x == 99 || y == 0 || y == 99) d = 8'hFF;
`endif
        exp_addr_q.push_back(a[17:0]);
        exp_q.push_back({(x == 99 && y == 99), d});
      end
    end
  endtask

  always @(negedge clk) begin
    int used;
    logic [17:0] ea;
    logic [8:0]  ep;
    if (!mon_en) begin
      m_issued   = 0;
      m_acc      = 0;
      prev_stall = 0;
    end else begin
      used = m_issued - m_acc;
      n_checks++;
      if (used > 2 || (used == 2 && !(bus.pixel_valid && bus.pixel_ready) && bus.mem_rd_en)) begin
        n_fail++;
        $display("FAIL credit: used=%0d rd_en=%b valid=%b ready=%b (required used<=2, no read when full)",
                 used, bus.mem_rd_en, bus.pixel_valid, bus.pixel_ready);
      end
      if (prev_stall) begin
        n_checks++;
        if (!bus.pixel_valid || bus.pixel !== prev_pix || bus.pixel_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b pixel=%h last=%b, required valid=1 pixel=%h last=%b",
                   bus.pixel_valid, bus.pixel, bus.pixel_last, prev_pix, prev_last);
        end
      end
      if (bus.mem_rd_en) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL addr: unexpected read at %0d, required no read", bus.mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (bus.mem_addr !== ea) begin
            n_fail++;
            $display("FAIL addr: got %0d, required %0d", bus.mem_addr, ea);
          end
        end
        m_issued++;
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel: unexpected pixel %h, required none", bus.pixel);
        end else begin
          ep = exp_q.pop_front();
          if ({bus.pixel_last, bus.pixel} !== ep) begin
            n_fail++;
            $display("FAIL pixel: got last=%b data=%h, required last=%b data=%h",
                     bus.pixel_last, bus.pixel, ep[8], ep[7:0]);
          end
        end
        m_acc++;
      end
      prev_stall = bus.pixel_valid && !bus.pixel_ready;
      prev_pix   = bus.pixel;
      prev_last  = bus.pixel_last;
    end
  end

  // ---------------- frame driver ----------------
  int         f_done_cyc, f_last_cyc, f_n_done, f_acc, f_first_valid;
  logic       f_busy1, f_rden1, f_busy_at_done, f_stall_rden, f_stall_valid;
  logic [17:0] f_addr1;
  logic [7:0] f_pix0, f_pix101;

  // ready_mode 0: always ready; 1: random 50% with cycles 200..204 held low.
  task automatic run_frame(input logic [3:0] q, input bit pre_started, input int ready_mode,
                           input int ignore_at, input int stop_at, input bit chain,
                           input logic [3:0] next_q, input int budget);
    int k;
    bit pulsed;
    f_done_cyc = -1; f_last_cyc = -1; f_n_done = 0; f_acc = 0; f_first_valid = -1;
    f_stall_rden = 0; f_stall_valid = 1; f_busy_at_done = 1'bx;
    pulsed = 0;
    if (!pre_started) begin
      @(negedge clk);
      bus.cuadrante = q;
      bus.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.pixel_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        f_busy1 = bus.busy; f_rden1 = bus.mem_rd_en; f_addr1 = bus.mem_addr;
      end
      if (bus.pixel_valid && f_first_valid < 0) f_first_valid = k;
      if (ready_mode == 1 && k >= 202 && k <= 204) begin
        f_stall_rden  = f_stall_rden | bus.mem_rd_en;
        f_stall_valid = f_stall_valid & bus.pixel_valid;
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        if (f_acc == 0)   f_pix0   = bus.pixel;
        if (f_acc == 101) f_pix101 = bus.pixel;
        f_acc++;
        if (bus.pixel_last) f_last_cyc = k;
      end
      if (bus.done) begin
        f_n_done++;
        if (f_done_cyc < 0) begin
          f_done_cyc = k;
          f_busy_at_done = bus.busy;
        end
      end
      if (stop_at > 0 && f_acc >= stop_at) break;
      if (f_done_cyc >= 0 && chain) begin
        bus.start = 1'b1;
        bus.cuadrante = next_q;
        break;
      end
      if (f_done_cyc >= 0 && k >= f_done_cyc + 3) break;
      if (k >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: frame q=%h not finished after %0d cycles, required done", q, k);
        break;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (ignore_at > 0 && !pulsed && f_acc >= ignore_at) begin
        bus.start = 1'b1;
        bus.cuadrante = 4'hF;
        pulsed = 1;
      end
      if (ready_mode == 1)
        bus.pixel_ready = (k + 1 >= 200 && k + 1 <= 204) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        bus.pixel_ready = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.pixel_valid, bus.pixel_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/rd/valid/last=%b, required 00000",
               {bus.busy, bus.done, bus.mem_rd_en, bus.pixel_valid, bus.pixel_last});
    end
    n_checks++;
    if (bus.mem_addr !== 18'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d, required 0", bus.mem_addr);
    end
    n_checks++;
    if (bus.pixel !== 8'd0) begin
      n_fail++; $display("FAIL reset_pixel: got %h, required 00", bus.pixel);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d, required 0", state_dbg);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: busy=%b rd_en=%b, required 0 0", bus.busy, bus.mem_rd_en);
    end
  endtask

  task automatic test_reset_mid_frame;
    push_frame(4'd0);
    mon_en = 1;
    run_frame(4'd0, 0, 0, 0, 500, 0, 4'd0, 12000);
    mon_en = 0;
    n_checks++;
    if (f_acc !== 500) begin
      n_fail++; $display("FAIL midreset_count: got %0d pixels, required 500", f_acc);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.pixel_valid, bus.pixel_last} !== 5'b0 ||
        bus.mem_addr !== 18'd0 || bus.pixel !== 8'd0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags=%b addr=%0d pixel=%h state=%0d, required all 0",
               {bus.busy, bus.done, bus.mem_rd_en, bus.pixel_valid, bus.pixel_last},
               bus.mem_addr, bus.pixel, state_dbg);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.pixel_valid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale: cycle %0d valid=%b rd_en=%b, required 0 0",
                 i, bus.pixel_valid, bus.mem_rd_en);
      end
    end
  endtask

  task automatic test_basic_frame;
    push_frame(4'd0);
    mon_en = 1;
    run_frame(4'd0, 0, 0, 0, 0, 0, 4'd0, 12000);
    mon_en = 0;
    n_checks++;
    if (f_busy1 !== 1'b1 || f_rden1 !== 1'b1 || f_addr1 !== 18'd0) begin
      n_fail++;
      $display("FAIL basic_cycle1: busy=%b rd_en=%b addr=%0d, required 1 1 0", f_busy1, f_rden1, f_addr1);
    end
    n_checks++;
    if (f_first_valid !== 3) begin
      n_fail++; $display("FAIL basic_first_valid: cycle %0d, required 3", f_first_valid);
    end
    n_checks++;
    if (f_last_cyc !== 10002) begin
      n_fail++; $display("FAIL basic_last_cycle: cycle %0d, required 10002", f_last_cyc);
    end
    n_checks++;
    if (f_done_cyc !== 10003 || f_n_done !== 1) begin
      n_fail++; $display("FAIL basic_done: cycle %0d count %0d, required cycle 10003 count 1", f_done_cyc, f_n_done);
    end
    n_checks++;
    if (f_busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_at_done: got %b, required 0", f_busy_at_done);
    end
    n_checks++;
    if (f_acc !== 10000 || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_count: pixels %0d, left exp %0d addr %0d, required 10000 0 0",
               f_acc, exp_q.size(), exp_addr_q.size());
    end
  endtask

  task automatic test_border_pixels;
    logic [7:0] exp0;
`ifdef QUAD_READER_BORDER_EN
    exp0 = 8'hFF;
`else
    exp0 = 8'h00;
`endif
    n_checks++;
    if (f_pix0 !== exp0) begin
      n_fail++; $display("FAIL border_corner: got %h, required %h", f_pix0, exp0);
    end
    n_checks++;
    if (f_pix101 !== 8'd145) begin
      n_fail++; $display("FAIL inner_pixel_1_1: got %0d, required 145", f_pix101);
    end
  endtask

  task automatic test_back_to_back;
    push_frame(4'd5);
    push_frame(4'b1011);
    mon_en = 1;
    // frame 1: tile (1,1) with start/cuadrante disturbed at pixel 300
    run_frame(4'd5, 0, 0, 300, 0, 1, 4'b1011, 12000);
    n_checks++;
    if (f_done_cyc !== 10003 || f_acc !== 10000 || f_n_done !== 1) begin
      n_fail++;
      $display("FAIL ignored_frame: done cycle %0d pixels %0d dones %0d, required 10003 10000 1",
               f_done_cyc, f_acc, f_n_done);
    end
    // frame 2: started in the done cycle, tile (2,3)
    run_frame(4'b1011, 1, 0, 0, 0, 0, 4'd0, 12000);
    mon_en = 0;
    n_checks++;
    if (f_addr1 !== 18'd80300 || f_rden1 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first_addr: addr %0d rd_en %b, required 80300 1", f_addr1, f_rden1);
    end
    n_checks++;
    if (f_first_valid !== 3 || f_done_cyc !== 10003 || f_n_done !== 1) begin
      n_fail++;
      $display("FAIL b2b_timing: first valid %0d done %0d dones %0d, required 3 10003 1",
               f_first_valid, f_done_cyc, f_n_done);
    end
    n_checks++;
    if (f_acc !== 10000 || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: pixels %0d, left exp %0d addr %0d, required 10000 0 0",
               f_acc, exp_q.size(), exp_addr_q.size());
    end
  endtask

  task automatic test_backpressure;
    push_frame(4'b0110);
    mon_en = 1;
    run_frame(4'b0110, 0, 1, 0, 0, 0, 4'd0, 40000);
    mon_en = 0;
    bus.pixel_ready = 1'b1;
    n_checks++;
    if (f_stall_rden !== 1'b0 || f_stall_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: rd_en seen %b valid held %b, required 0 1", f_stall_rden, f_stall_valid);
    end
    n_checks++;
    if (f_acc !== 10000 || f_n_done !== 1 || f_done_cyc !== f_last_cyc + 1) begin
      n_fail++;
      $display("FAIL bp_frame: pixels %0d dones %0d done %0d last %0d, required 10000 1 last+1",
               f_acc, f_n_done, f_done_cyc, f_last_cyc);
    end
    n_checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_fail++; $display("FAIL bp_leftover: exp %0d addr %0d, required 0 0", exp_q.size(), exp_addr_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cuadrante = 4'd0;
    bus.pixel_ready = 1'b1;
    test_reset();
    test_reset_mid_frame();
    test_basic_frame();
    test_border_pixels();
    test_back_to_back();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
